// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 target: receives 16-bit {wr, addr[6:0], data[7:0]} frames
// and holds the five configuration registers that feed pwm_peripheral.
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;
  localparam int         NUM_REGS = 5;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ncs_prev_q,  ncs_prev_d;

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        ovf_q,   ovf_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;
  logic commit_ok;

  // All three chains share one depth so copi stays aligned with the sclk edge it belongs to.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign ncs_prev_d  = ncs_s;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  assign commit_ok = (cnt_q == 5'd16) && !ovf_q && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;
    regs_d  = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_RECV;
        end
      end
      default: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
        end else if (ncs_rise) begin
          // ncs_rise takes priority over a coincident sclk_rise, which is dropped.
          if (commit_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
            end
          end
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          if (cnt_q < 5'd16) begin
            shift_d = {shift_q[14:0], copi_s};
            cnt_d   = cnt_q + 5'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ovf_q       <= 1'b0;
      // NOTE: the register array is real configuration state, so each entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ncs_prev_q  <= ncs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ovf_q       <= ovf_d;
      regs_q      <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench for spi_reg_peripheral: the sender pushes the expected register
// image at each frame end; a monitor checks it around the 3-edge commit point.
`timescale 1ns/1ps
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [39:0] model    = '0;
  logic [39:0] last_exp = '0;
  logic [39:0] exp_q[$];
  event        push_ev;

  spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] regs_now();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends bits[n-1:0] MSB first with 3-clk sclk phases, then raises ncs and
  // publishes the expected register image.
  task automatic send_frame(input logic [16:0] bits, input int n);
    int a;
    @(negedge clk);
    ncs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
    a = int'(bits[14:8]);
    if (n == 16 && bits[15] && a <= 4) model[8*a +: 8] = bits[7:0];
    exp_q.push_back(model);
    -> push_ev;
    ncs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: registers must still hold the old image after 2 edges and the new one after 3.
  initial begin
    logic [39:0] e;
    forever begin
      @(push_ev);
      e = exp_q.pop_front();
      repeat (2) @(posedge clk);
      #1 check("pre_commit", regs_now(), last_exp);
      @(posedge clk);
      #1 check("commit", regs_now(), e);
      last_exp = e;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;

    // Reset with random pin activity.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sclk = 1'($urandom); copi = 1'($urandom); ncs = 1'($urandom);
    end
    check("reset_hold", regs_now(), 40'h0);
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_release", regs_now(), 40'h0);

    // Directed writes to all five registers.
    send_frame(17'h080F0, 16);
    send_frame(17'h08104, 16);
    send_frame(17'h082AA, 16);
    send_frame(17'h08355, 16);
    send_frame(17'h08480, 16);
    check("all_writes", regs_now(), 40'h80_55_AA_04_F0);

    // Read frame and out-of-range writes are discarded.
    send_frame(17'h00012, 16);
    send_frame(17'h085FF, 16);
    send_frame(17'h0FF11, 16);
    check("ignored_frames", regs_now(), 40'h80_55_AA_04_F0);

    // Short (first 15 bits of 0x8433) and long (0x8433 plus one bit) frames.
    send_frame(17'h08433 >> 1, 15);
    send_frame({16'h8433, 1'b1}, 17);
    check("short_long", regs_now(), 40'h80_55_AA_04_F0);
    send_frame(17'h08433, 16);
    check("duty_33", regs_now(), 40'h33_55_AA_04_F0);

    // Asynchronous reset after 8 bits of 0x80FF.
    @(negedge clk);
    ncs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      copi = (i == 7);
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", regs_now(), 40'h0);
    ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(17'h08011, 16);
    check("after_reset_write", regs_now(), 40'h00_00_00_00_11);

    // Minimum-timing random writes across all addresses.
    for (int i = 0; i < 200; i++) begin
      logic [16:0] f;
      f = {1'b0, 1'b1, 7'(i % 5), 8'($urandom)};
      send_frame(f, 16);
    end

    // sclk activity with ncs high must not disturb anything.
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom);
      repeat (3) @(negedge clk);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_sclk", regs_now(), model);

    repeat (10) @(negedge clk);
    check("queue_drained", 40'(exp_q.size()), 40'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
